// File: rtl/icache_fetcher_if.sv
// Fetch-stage bus bundle: memory-controller request/response, instruction
// queue output register and ROB redirect. The fetcher uses the master view,
// the surrounding pipeline (or a bench) uses the slave view.
interface icache_fetcher_if;
  logic        en_to_mem;
  logic [31:0] pc_to_mem;
  logic        ok_from_mem;
  logic [31:0] inst_from_mem;
  logic        iq_full_in;
  logic        inst_valid_to_iq;
  logic [31:0] inst_to_iq;
  logic [31:0] pc_to_iq;
  logic        jump_flag_in;
  logic [31:0] jump_pc_in;

  modport master (
    output en_to_mem,
    output pc_to_mem,
    input  ok_from_mem,
    input  inst_from_mem,
    input  iq_full_in,
    output inst_valid_to_iq,
    output inst_to_iq,
    output pc_to_iq,
    input  jump_flag_in,
    input  jump_pc_in
  );

  modport slave (
    input  en_to_mem,
    input  pc_to_mem,
    output ok_from_mem,
    output inst_from_mem,
    output iq_full_in,
    input  inst_valid_to_iq,
    input  inst_to_iq,
    input  pc_to_iq,
    output jump_flag_in,
    output jump_pc_in
  );
endinterface

// File: rtl/icache_fetcher.sv
// Instruction fetch stage with a direct-mapped, one-word-per-line cache.
// Holds the PC, delivers {pc, inst} to the instruction queue through a
// one-entry output register, and issues single-word fetches on a miss.
// A redirect while a fetch is in flight parks the FSM in DRAIN so the late
// response still fills its own line but is never delivered.
module icache_fetcher #(
  parameter int          INDEX_BITS = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  icache_fetcher_if.master bus
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // FSM and fetch-side registers
  state_t               r_state;
  state_t               w_state_nxt;
  logic [31:0]          r_pc;
  logic [31:0]          w_pc_nxt;
  logic [29:0]          r_miss_pc;      // word address of the outstanding fetch
  logic [29:0]          w_miss_pc_nxt;
  logic                 r_en_to_mem;
  logic                 w_en_to_mem_nxt;
  logic [31:0]          r_pc_to_mem;
  logic [31:0]          w_pc_to_mem_nxt;

  // Output register towards the instruction queue
  logic                 r_iq_valid;
  logic                 w_iq_valid_nxt;
  logic [31:0]          r_iq_inst;
  logic [31:0]          w_iq_inst_nxt;
  logic [31:0]          r_iq_pc;
  logic [31:0]          w_iq_pc_nxt;

  // Cache storage: valid bits are reset, tag/data arrays are not
  logic [LINES-1:0]     r_line_valid;
  logic [TAG_BITS-1:0]  r_tag_mem  [LINES];
  logic [31:0]          r_data_mem [LINES];

  // Decode
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_fill_index;
  logic [TAG_BITS-1:0]   w_fill_tag;
  logic                  w_hit;
  logic                  w_transfer;
  logic                  w_slot_free;
  logic                  w_fill;
  logic [31:0]           w_jump_pc;

  assign bus.en_to_mem        = r_en_to_mem;
  assign bus.pc_to_mem        = r_pc_to_mem;
  assign bus.inst_valid_to_iq = r_iq_valid;
  assign bus.inst_to_iq       = r_iq_inst;
  assign bus.pc_to_iq         = r_iq_pc;

  // Address split, cache lookup and IQ handshake decode
  always_comb begin
    w_index      = r_pc[INDEX_BITS+1:2];
    w_tag        = r_pc[31:INDEX_BITS+2];
    w_fill_index = r_miss_pc[INDEX_BITS-1:0];
    w_fill_tag   = r_miss_pc[29:INDEX_BITS];
    w_hit        = r_line_valid[w_index] && (r_tag_mem[w_index] == w_tag);
    w_transfer   = r_iq_valid && !bus.iq_full_in;
    w_slot_free  = !r_iq_valid || w_transfer;
    w_jump_pc    = bus.jump_pc_in & 32'hFFFF_FFFC;
  end

  // Next-state and next-output logic; redirect outranks fill, fill outranks lookup
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_miss_pc_nxt   = r_miss_pc;
    w_en_to_mem_nxt = 1'b0;
    w_pc_to_mem_nxt = r_pc_to_mem;
    w_iq_valid_nxt  = r_iq_valid && !w_transfer;
    w_iq_inst_nxt   = r_iq_inst;
    w_iq_pc_nxt     = r_iq_pc;
    w_fill          = 1'b0;

    if (bus.jump_flag_in) begin
      w_pc_nxt       = w_jump_pc;
      w_iq_valid_nxt = 1'b0;
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_IDLE;
        end
        ST_WAIT, ST_DRAIN: begin
          if (bus.ok_from_mem) begin
            w_fill      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          // A response arriving here is stale and deliberately ignored
          if (w_slot_free) begin
            if (w_hit) begin
              w_iq_valid_nxt = 1'b1;
              w_iq_inst_nxt  = r_data_mem[w_index];
              w_iq_pc_nxt    = r_pc;
              w_pc_nxt       = r_pc + 32'd4;
            end else begin
              w_en_to_mem_nxt = 1'b1;
              w_pc_to_mem_nxt = r_pc;
              w_miss_pc_nxt   = r_pc[31:2];
              w_state_nxt     = ST_WAIT;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_WAIT, ST_DRAIN: begin
          // The filled word is picked up by the next IDLE lookup as a hit
          if (bus.ok_from_mem) begin
            w_fill      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = r_state;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state register, frozen while the global ready is low
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
    end
  end

  // PC, request and output registers plus line valid bits
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pc         <= RESET_PC;
      r_miss_pc    <= 30'd0;
      r_en_to_mem  <= 1'b0;
      r_pc_to_mem  <= 32'd0;
      r_iq_valid   <= 1'b0;
      r_iq_inst    <= 32'd0;
      r_iq_pc      <= 32'd0;
      r_line_valid <= {LINES{1'b0}};
    end else if (rdy_in) begin
      r_pc        <= w_pc_nxt;
      r_miss_pc   <= w_miss_pc_nxt;
      r_en_to_mem <= w_en_to_mem_nxt;
      r_pc_to_mem <= w_pc_to_mem_nxt;
      r_iq_valid  <= w_iq_valid_nxt;
      r_iq_inst   <= w_iq_inst_nxt;
      r_iq_pc     <= w_iq_pc_nxt;
      if (w_fill) begin
        r_line_valid[w_fill_index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays: written only by a fill, contents survive reset
  always_ff @(posedge clk_in) begin
    if (rdy_in && w_fill) begin
      r_tag_mem[w_fill_index]  <= w_fill_tag;
      r_data_mem[w_fill_index] <= bus.inst_from_mem;
    end
  end

endmodule

// File: tb/tb_icache_fetcher.sv
// Bench for icache_fetcher: a memory-controller model answers fetches with a
// fixed program image; the reference model is the architectural instruction
// stream (pc, pc+4, ... restarting at each redirect target) held in a queue,
// and a negedge monitor pops and compares every IQ transfer.
module tb_icache_fetcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  icache_fetcher_if bus ();

  icache_fetcher #(.INDEX_BITS(8), .RESET_PC(32'h0000_0000)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .rdy_in (rdy),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_xfer = 0;
  int call_no = 0;

  // Memory controller model state
  bit          mem_busy  = 1'b0;
  bit          mem_bogus = 1'b0;
  int          mem_cnt   = 0;
  logic [31:0] mem_addr  = 32'd0;
  int          mem_lat_min = 0;
  int          mem_lat_max = 0;
  int          ok_call   = 0;

  // Expected instruction stream
  logic [63:0] exp_q[$];
  logic [31:0] exp_next = 32'd0;

  // Program image seen by the fetcher: word 0 is the RISC-V nop 0x00000013
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic restart_stream(input logic [31:0] start);
    exp_q.delete();
    exp_next = start & 32'hFFFF_FFFC;
  endtask

  task automatic top_up();
    while (exp_q.size() < 4) begin
      exp_q.push_back({exp_next, mem_word(exp_next)});
      exp_next = exp_next + 32'd4;
    end
  endtask

  // One clock cycle: drive inputs at posedge+1, run memory model, advance
  task automatic cycle(input bit r, input bit f, input bit j, input logic [31:0] jpc);
    call_no++;
    rdy              = r;
    bus.iq_full_in   = f;
    bus.jump_flag_in = j;
    bus.jump_pc_in   = jpc;
    if (mem_busy && mem_cnt == 0) begin
      bus.ok_from_mem   = 1'b1;
      bus.inst_from_mem = mem_bogus ? 32'hDEAD_BEEF : mem_word(mem_addr);
    end else begin
      bus.ok_from_mem   = 1'b0;
      bus.inst_from_mem = 32'd0;
    end
    if (r) begin
      if (bus.en_to_mem) begin
        check("one_outstanding", {63'd0, mem_busy}, 64'd0);
      end
      if (bus.ok_from_mem) begin
        mem_busy  = 1'b0;
        mem_bogus = 1'b0;
        ok_call   = call_no;
      end else if (mem_busy) begin
        mem_cnt--;
      end
      if (bus.en_to_mem) begin
        mem_busy = 1'b1;
        mem_addr = bus.pc_to_mem;
        mem_cnt  = int'($urandom_range(mem_lat_max, mem_lat_min));
      end
      if (j) begin
        restart_stream(jpc);
      end
    end
    top_up();
    @(posedge clk);
    #1;
  endtask

  // Optionally redirect, then run until a fetch request or delivery of tgt
  task automatic run_until(input bit do_jump, input logic [31:0] tgt,
                           output bit got_req, output logic [31:0] addr, output int at_call);
    got_req = 1'b0;
    addr    = 32'd0;
    at_call = 0;
    if (do_jump) begin
      cycle(1'b1, 1'b0, 1'b1, tgt);
      check("redir_valid_clear", {63'd0, bus.inst_valid_to_iq}, 64'd0);
      check("redir_no_request", {63'd0, bus.en_to_mem}, 64'd0);
    end
    for (int i = 0; i < 60; i++) begin
      if (bus.en_to_mem) begin
        got_req = 1'b1;
        addr    = bus.pc_to_mem;
        at_call = call_no;
        break;
      end
      if (bus.inst_valid_to_iq && bus.pc_to_iq == tgt) begin
        at_call = call_no;
        break;
      end
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
    end
    if (at_call == 0) begin
      fail_now("run_until_timeout");
    end
  endtask

  task automatic do_reset(input bit stale);
    rst = 1'b1;
    #1;
    check("rst_en_to_mem", {63'd0, bus.en_to_mem}, 64'd0);
    check("rst_pc_to_mem", {32'd0, bus.pc_to_mem}, 64'd0);
    check("rst_valid", {63'd0, bus.inst_valid_to_iq}, 64'd0);
    check("rst_inst", {32'd0, bus.inst_to_iq}, 64'd0);
    check("rst_pc_iq", {32'd0, bus.pc_to_iq}, 64'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    mem_busy  = stale;
    mem_bogus = stale;
    mem_cnt   = 0;
    restart_stream(32'h0000_0000);
  endtask

  // Monitor: every IQ transfer must be the next word of the expected stream
  always @(negedge clk) begin
    if (!rst && rdy && bus.inst_valid_to_iq && !bus.iq_full_in && !bus.jump_flag_in) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL iq_unexpected: got pc %h expected no transfer", bus.pc_to_iq);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("iq_pc", {32'd0, bus.pc_to_iq}, {32'd0, e[63:32]});
        check("iq_inst", {32'd0, bus.inst_to_iq}, {32'd0, e[31:0]});
      end
    end
  end

  initial begin
    bit          got;
    logic [31:0] a;
    logic [31:0] caddr;
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    int          at;
    int          jc;

    bus.ok_from_mem   = 1'b0;
    bus.inst_from_mem = 32'd0;
    bus.iq_full_in    = 1'b0;
    bus.jump_flag_in  = 1'b0;
    bus.jump_pc_in    = 32'd0;
    @(posedge clk);
    #1;
    do_reset(1'b0);

    // Cold start: miss at 0, memory answers 0x13 after ~6 cycles
    mem_lat_min = 5;
    mem_lat_max = 5;
    run_until(1'b0, 32'h0, got, a, at);
    check("cold_req", {63'd0, got}, 64'd1);
    check("cold_req_pc", {32'd0, a}, 64'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    run_until(1'b0, 32'h0, got, a, at);
    check("cold_deliver_latency", at, ok_call + 1);
    check("cold_inst", {32'd0, bus.inst_to_iq}, 64'h13);
    run_until(1'b0, 32'h4, got, a, at);
    check("cold_next_req_pc", {32'd0, a}, 64'd4);

    // Fill lines 0..4, then redirect to 0 and stream hits
    mem_lat_min = 2;
    mem_lat_max = 2;
    for (int i = 0; i < 200; i++) begin
      if (n_xfer >= 5) break;
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
    end
    run_until(1'b1, 32'h0, got, a, at);
    check("stream_no_req", {63'd0, got}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", {63'd0, bus.inst_valid_to_iq}, 64'd1);
      check("stream_pc", {32'd0, bus.pc_to_iq}, 64'(i * 4));
      check("stream_en", {63'd0, bus.en_to_mem}, 64'd0);
      if (i < 3) cycle(1'b1, 1'b0, 1'b0, 32'd0);
    end

    // Backpressure: output held, no request, then next pc right after release
    hold_pc   = bus.pc_to_iq;
    hold_inst = bus.inst_to_iq;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 32'd0);
      check("bp_valid", {63'd0, bus.inst_valid_to_iq}, 64'd1);
      check("bp_pc", {32'd0, bus.pc_to_iq}, {32'd0, hold_pc});
      check("bp_inst", {32'd0, bus.inst_to_iq}, {32'd0, hold_inst});
      check("bp_en", {63'd0, bus.en_to_mem}, 64'd0);
    end
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    check("bp_release_pc", {32'd0, bus.pc_to_iq}, 64'h10);

    // Redirect two cycles into a miss: drain, fill own line, then fetch target
    mem_lat_min = 8;
    mem_lat_max = 8;
    run_until(1'b1, 32'h40, got, a, at);
    check("wait_miss_pc", {32'd0, a}, 64'h40);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    run_until(1'b1, 32'h100, got, a, at);
    check("drain_req", {63'd0, got}, 64'd1);
    check("drain_req_pc", {32'd0, a}, 64'h100);
    run_until(1'b1, 32'h40, got, a, at);
    check("drain_filled_hit", {63'd0, got}, 64'd0);

    // Redirect in the very cycle the response arrives
    mem_lat_min = 3;
    mem_lat_max = 3;
    for (int i = 0; i < 40; i++) begin
      if (mem_busy && mem_cnt == 0) break;
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
    end
    caddr = mem_addr;
    jc    = call_no + 1;
    run_until(1'b1, 32'h200, got, a, at);
    check("coinc_ok_in_jump", ok_call, jc);
    check("coinc_req_pc", {32'd0, a}, 64'h200);
    run_until(1'b1, caddr, got, a, at);
    check("coinc_filled_hit", {63'd0, got}, 64'd0);

    // Alias on index 0: 0x400 replaces 0x000
    mem_lat_min = 0;
    mem_lat_max = 4;
    run_until(1'b1, 32'h0, got, a, at);
    check("alias_pre_hit", {63'd0, got}, 64'd0);
    run_until(1'b1, 32'h400, got, a, at);
    check("alias_miss_pc", {32'd0, a}, 64'h400);
    run_until(1'b1, 32'h0, got, a, at);
    check("alias_remiss_pc", {32'd0, a}, 64'h0);

    // Reset mid-WAIT; the late response lands in IDLE and must be dropped
    run_until(1'b1, 32'h800, got, a, at);
    check("rstwait_req_pc", {32'd0, a}, 64'h800);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'd0);
    do_reset(1'b1);
    run_until(1'b1, 32'h0, got, a, at);
    check("rstwait_stale_ignored", {63'd0, got}, 64'd1);
    check("rstwait_req_pc0", {32'd0, a}, 64'h0);

    // Randomised traffic: stalls, backpressure, redirects incl. wrap region
    mem_lat_min = 0;
    mem_lat_max = 5;
    for (int i = 0; i < 3000; i++) begin
      bit          r;
      bit          f;
      bit          j;
      logic [31:0] t;
      r = ($urandom_range(99, 0) < 85);
      f = ($urandom_range(99, 0) < 30);
      j = ($urandom_range(99, 0) < 4);
      if ($urandom_range(3, 0) == 0) begin
        t = 32'hFFFF_FFF0 + ($urandom_range(3, 0) * 4) + $urandom_range(3, 0);
      end else begin
        t = $urandom_range(4095, 0);
      end
      cycle(r, f, j, t);
    end
    for (int i = 0; i < 60; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'd0);
    end
    check("activity", {63'd0, (n_xfer > 300)}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
